imem_dmem_arbiter: RTL and testbench
====================================

Name: imem_dmem_arbiter

Overview:
- Shares one single-port unified memory between the core's instruction-fetch port and its data port.
- Both requester ports and the memory port use valid/ready handshakes.
- Exactly one transaction is in flight at a time. Every request, stores included, receives exactly one response.
- Data requests have priority; a starvation counter guarantees forward progress for fetch.

Parameters:
ADDR_WIDTH, 32, address width on all ports
DATA_WIDTH, 32, data width on all ports
STARVE_LIMIT, 4, maximum consecutive data grants while a fetch is pending (must be ≥ 1)

Ports:
clk  in  1  clock; single clock domain, rising edge
async_rst_n  in  1  reset, asynchronous, active-low
if_req_addr  in  ADDR_WIDTH  fetch address (PC)
if_req_valid  in  1  fetch request valid
if_req_ready  out  1  fetch request accepted
if_rsp_data  out  DATA_WIDTH  instruction word
if_rsp_valid  out  1  instruction valid
if_rsp_ready  in  1  fetch side accepts instruction
d_req_we  in  1  1 = store, 0 = load
d_req_addr  in  ADDR_WIDTH  data address
d_req_wdata  in  DATA_WIDTH  store data
d_req_be  in  4  byte enables
d_req_valid  in  1  data request valid
d_req_ready  out  1  data request accepted
d_rsp_data  out  DATA_WIDTH  load data (don't-care for stores)
d_rsp_valid  out  1  data response valid
d_rsp_ready  in  1  data side accepts response
mem_req_we  out  1  memory write enable
mem_req_addr  out  ADDR_WIDTH  memory address
mem_req_wdata  out  DATA_WIDTH  memory write data
mem_req_be  out  4  memory byte enables (4'b1111 for fetch)
mem_req_valid  out  1  memory request valid
mem_req_ready  in  1  memory accepts request
mem_rsp_data  in  DATA_WIDTH  memory read data
mem_rsp_valid  in  1  memory response valid
mem_rsp_ready  out  1  arbiter accepts response

Behaviour:
- Reset values:
  - State = IDLE; owner = DATA; starve counter = 0; request register = 0.
  - All *_ready, *_valid, mem_req_* outputs are 0.
- Handshake rules:
  - A transfer occurs on a clock edge where valid && ready.
  - Requesters must hold payload stable while valid is high and ready is low.
- IDLE:
  - Grant evaluated combinationally from d_req_valid, if_req_valid and the counter.
  - Data is granted if d_req_valid && !(if_req_valid && cnt == STARVE_LIMIT); otherwise fetch is granted if if_req_valid.
  - The grantee's req_ready = 1 in the same cycle; the other requester's req_ready = 0.
  - On grant: latch {we, addr, wdata, be} and owner into the request register, then go to ISSUE.
  - Fetch latches we = 0, be = 4'b1111, wdata = 0.
  - No request pending: stay in IDLE.
- ISSUE:
  - mem_req_valid = 1, driven only from the request register.
  - On mem_req_ready: go to WAIT.
  - Requester req_ready = 0 in ISSUE and WAIT.
- WAIT:
  - mem_rsp_ready = owner's rsp_ready.
  - Owner's rsp_valid = mem_rsp_valid; owner's rsp_data = mem_rsp_data (combinational pass-through).
  - Non-owner rsp_valid = 0.
  - On mem_rsp_valid && owner rsp_ready: go to IDLE.
- Latency:
  - Request accepted at cycle N; mem_req_valid high at N+1.
  - Response delivered in the cycle the memory presents it.
  - Minimum 3 cycles per transaction; back-to-back grant possible in the cycle after WAIT exits.
- Starvation counter:
  - Data grant while if_req_valid = 1: counter increments, saturating at STARVE_LIMIT.
  - Fetch grant: counter clears to 0.
  - Data grant with if_req_valid = 0: counter clears to 0.
- Boundary conditions:
  - Simultaneous requests with counter < limit: data wins.
  - Simultaneous requests with counter == limit: fetch wins.
  - mem_rsp_valid in IDLE or ISSUE: ignored, mem_rsp_ready = 0; no state change.
  - mem_req_ready asserted outside ISSUE: no effect.
  - Owner holds rsp_ready low: stay in WAIT indefinitely; memory back-pressured via mem_rsp_ready.
  - Reset mid-transaction: immediately returns to IDLE, the in-flight transaction is dropped, and all outputs take reset values. The memory must also be reset.

Decomposition:
- rv32i_types_pkg additions:
  - arb_state_t enum {IDLE, ISSUE, WAIT}
  - arb_owner_t enum {OWN_FETCH, OWN_DATA}
  - mem_req_t packed struct {we, addr, wdata, be}
- One sub-module: arb_priority_select. Contains the combinational grant decision plus the registered starvation counter. Inputs: the two valids and the IDLE qualifier. Outputs: grant_fetch, grant_data.

Test Plan:
- Single fetch, addr 0x0000_0010; memory ready immediately, returns 0x0000_0013 one cycle later → if_req_ready at cycle 0, mem_req_valid at cycle 1 with be = 4'hF and we = 0, if_rsp_data = 0x0000_0013; d_rsp_valid stays 0.
- Store addr 0x100, wdata 0xDEADBEEF, be = 4'b0011 → mem_req_we = 1, payload forwarded unchanged, one d_rsp_valid pulse, if_* untouched.
- Both requesters held valid continuously, STARVE_LIMIT = 4 → grant sequence D,D,D,D,F,D,D,D,D,F; counter returns to 0 after each F.
- mem_req_ready held low 5 cycles in ISSUE → mem_req_* payload stable all 5 cycles, no new grants; then 1 → WAIT.
- In WAIT, owner rsp_ready = 0 for 3 cycles while mem_rsp_valid = 1 → mem_rsp_ready = 0, state holds; releasing rsp_ready completes the transfer and returns to IDLE.
- async_rst_n pulsed low during WAIT, plus a stray mem_rsp_valid in IDLE → outputs reset asynchronously, state = IDLE, stray response ignored (mem_rsp_ready = 0), next fetch served normally.

Source files
------------

// File: rtl/imem_dmem_arbiter_pkg.sv
// Shared types for the instruction/data memory arbiter.
// The request register, FSM states and owner tag all live here so that the
// top level, the priority selector and the testbench agree on one encoding.
package imem_dmem_arbiter_pkg;

   localparam int ARB_ADDR_W = 32;
   localparam int ARB_DATA_W = 32;
   localparam int ARB_BE_W   = 4;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT
   } arb_state_t;

   typedef enum logic {
      OWN_FETCH,
      OWN_DATA
   } arb_owner_t;

   typedef struct packed {
      logic                  we;
      logic [ARB_ADDR_W-1:0] addr;
      logic [ARB_DATA_W-1:0] wdata;
      logic [ARB_BE_W-1:0]   be;
   } mem_req_t;

   // A fetch is always a full-word read, so only the address varies.
   function automatic mem_req_t fetchReq(input logic [ARB_ADDR_W-1:0] addr);
      mem_req_t r;
      r.we    = 1'b0;
      r.addr  = addr;
      r.wdata = '0;
      r.be    = {ARB_BE_W{1'b1}};
      return r;
   endfunction

endpackage

// File: rtl/imem_dmem_arbiter_if.sv
// Bus bundle between the core's two memory ports, the arbiter and the
// unified memory. The slave modport is the arbiter's view: it receives the
// fetch and data requests and in turn masters the memory port. The master
// modport is the environment's view (core plus memory).
interface imem_dmem_arbiter_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);

   logic [ADDR_WIDTH-1:0] if_req_addr;
   logic                  if_req_valid;
   logic                  if_req_ready;
   logic [DATA_WIDTH-1:0] if_rsp_data;
   logic                  if_rsp_valid;
   logic                  if_rsp_ready;

   logic                  d_req_we;
   logic [ADDR_WIDTH-1:0] d_req_addr;
   logic [DATA_WIDTH-1:0] d_req_wdata;
   logic [3:0]            d_req_be;
   logic                  d_req_valid;
   logic                  d_req_ready;
   logic [DATA_WIDTH-1:0] d_rsp_data;
   logic                  d_rsp_valid;
   logic                  d_rsp_ready;

   logic                  mem_req_we;
   logic [ADDR_WIDTH-1:0] mem_req_addr;
   logic [DATA_WIDTH-1:0] mem_req_wdata;
   logic [3:0]            mem_req_be;
   logic                  mem_req_valid;
   logic                  mem_req_ready;
   logic [DATA_WIDTH-1:0] mem_rsp_data;
   logic                  mem_rsp_valid;
   logic                  mem_rsp_ready;

   modport slave (
      input  if_req_addr, if_req_valid, if_rsp_ready,
      output if_req_ready, if_rsp_data, if_rsp_valid,
      input  d_req_we, d_req_addr, d_req_wdata, d_req_be, d_req_valid, d_rsp_ready,
      output d_req_ready, d_rsp_data, d_rsp_valid,
      output mem_req_we, mem_req_addr, mem_req_wdata, mem_req_be, mem_req_valid, mem_rsp_ready,
      input  mem_req_ready, mem_rsp_data, mem_rsp_valid
   );

   modport master (
      output if_req_addr, if_req_valid, if_rsp_ready,
      input  if_req_ready, if_rsp_data, if_rsp_valid,
      output d_req_we, d_req_addr, d_req_wdata, d_req_be, d_req_valid, d_rsp_ready,
      input  d_req_ready, d_rsp_data, d_rsp_valid,
      input  mem_req_we, mem_req_addr, mem_req_wdata, mem_req_be, mem_req_valid, mem_rsp_ready,
      output mem_req_ready, mem_rsp_data, mem_rsp_valid
   );

endinterface

// File: rtl/imem_dmem_arbiter_arb_priority_select.sv
// Grant decision for the arbiter. Data normally wins, but once data has been
// granted STARVE_LIMIT times in a row while a fetch was waiting, the next
// contested grant goes to fetch. STARVE_LIMIT must be at least 1.
module arb_priority_select #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic clk,
   input  logic async_rst_n,
   input  logic if_valid_i,
   input  logic d_valid_i,
   input  logic idle_i,
   output logic grant_fetch_o,
   output logic grant_data_o
);

   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             fetchStarved;

   assign fetchStarved  = if_valid_i && (cnt_q == LIMIT);
   assign grant_data_o  = idle_i && d_valid_i && !fetchStarved;
   assign grant_fetch_o = idle_i && if_valid_i && !grant_data_o;

   // Count data grants that overtook a waiting fetch; any grant that leaves
   // no fetch waiting behind it (a fetch grant, or a data grant with no fetch
   // pending) restarts the count. Saturation is kept even though fetch wins
   // at the limit, so the counter can never wrap.
   always_comb begin
      cnt_d = cnt_q;
      if (grant_fetch_o) begin
         cnt_d = '0;
      end else if (grant_data_o) begin
         if (!if_valid_i) begin
            cnt_d = '0;
         end else if (cnt_q != LIMIT) begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // Starvation counter register.
   always_ff @(posedge clk or negedge async_rst_n) begin
      if (!async_rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/imem_dmem_arbiter.sv
// Shares one single-port memory between instruction fetch and data access.
// One transaction at a time: IDLE grants and captures the request, ISSUE
// presents it to memory from the captured copy, WAIT passes the memory
// response straight through to whichever port owns the transaction.
module imem_dmem_arbiter
   import imem_dmem_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH   = 32,
   parameter int DATA_WIDTH   = 32,
   parameter int STARVE_LIMIT = 4
) (
   input logic             clk,
   input logic             async_rst_n,
   imem_dmem_arbiter_if.slave bus
);

   arb_state_t state_q;
   arb_owner_t owner_q;
   mem_req_t   req_q;

   logic grantFetch;
   logic grantData;
   logic idleQual;
   logic inWait;
   logic ownerRspReady;

   // Grants are only offered in IDLE and never while reset is asserted, so
   // every ready output reads 0 during reset regardless of incoming valids.
   assign idleQual = (state_q == IDLE) && async_rst_n;

   arb_priority_select #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_prio (
      .clk           (clk),
      .async_rst_n   (async_rst_n),
      .if_valid_i    (bus.if_req_valid),
      .d_valid_i     (bus.d_req_valid),
      .idle_i        (idleQual),
      .grant_fetch_o (grantFetch),
      .grant_data_o  (grantData)
   );

   assign bus.if_req_ready = grantFetch;
   assign bus.d_req_ready  = grantData;

   assign bus.mem_req_valid = (state_q == ISSUE);
   assign bus.mem_req_we    = req_q.we;
   assign bus.mem_req_addr  = ADDR_WIDTH'(req_q.addr);
   assign bus.mem_req_wdata = DATA_WIDTH'(req_q.wdata);
   assign bus.mem_req_be    = req_q.be;

   assign inWait        = (state_q == WAIT);
   assign ownerRspReady = (owner_q == OWN_DATA) ? bus.d_rsp_ready : bus.if_rsp_ready;

   assign bus.mem_rsp_ready = inWait && ownerRspReady;
   assign bus.if_rsp_valid  = inWait && (owner_q == OWN_FETCH) && bus.mem_rsp_valid;
   assign bus.d_rsp_valid   = inWait && (owner_q == OWN_DATA) && bus.mem_rsp_valid;
   assign bus.if_rsp_data   = bus.mem_rsp_data;
   assign bus.d_rsp_data    = bus.mem_rsp_data;

   // Transaction sequencer. A grant captures the winner's payload and owner
   // tag; the memory request is then driven only from that copy, so the
   // requester is free to move on once it has been accepted. Responses and
   // memory readiness arriving in the wrong state are simply not looked at.
   always_ff @(posedge clk or negedge async_rst_n) begin
      if (!async_rst_n) begin
         state_q <= IDLE;
         owner_q <= OWN_DATA;
         req_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (grantData) begin
                  req_q   <= '{we:    bus.d_req_we,
                               addr:  ARB_ADDR_W'(bus.d_req_addr),
                               wdata: ARB_DATA_W'(bus.d_req_wdata),
                               be:    bus.d_req_be};
                  owner_q <= OWN_DATA;
                  state_q <= ISSUE;
               end else if (grantFetch) begin
                  req_q   <= fetchReq(ARB_ADDR_W'(bus.if_req_addr));
                  owner_q <= OWN_FETCH;
                  state_q <= ISSUE;
               end
            end
            ISSUE: begin
               if (bus.mem_req_ready) begin
                  state_q <= WAIT;
               end
            end
            WAIT: begin
               if (bus.mem_rsp_valid && ownerRspReady) begin
                  state_q <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Testbench for imem_dmem_arbiter. The bench keeps a transaction-level model
// of the arbiter (is a transaction outstanding, has memory taken it, who owns
// it, how many data grants have overtaken a waiting fetch) plus a small word
// memory and two requesters that hold their requests until accepted.
module tb_imem_dmem_arbiter;
   import imem_dmem_arbiter_pkg::*;

   localparam int LIMIT = 4;

   logic clk = 1'b0;
   logic async_rst_n;

   // Free-running 10 ns clock.
   always #5 clk = ~clk;

   imem_dmem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

   imem_dmem_arbiter #(
      .ADDR_WIDTH   (32),
      .DATA_WIDTH   (32),
      .STARVE_LIMIT (LIMIT)
   ) dut (
      .clk         (clk),
      .async_rst_n (async_rst_n),
      .bus         (bus)
   );

   int total = 0;
   int bad   = 0;
   int cycle = 0;

   int fProb, dProb, mrdyProb, rspProb, rrProb, strayProb;

   bit          fv;
   logic [31:0] fAddr;
   bit          dv;
   bit          dWe;
   logic [31:0] dAddr, dWdata;
   logic [3:0]  dBe;

   bit          busy, accepted, ownerData;
   bit          tWe;
   logic [31:0] tAddr, tWdata;
   logic [3:0]  tBe;
   int          streak;

   logic [31:0] memArr [256];
   bit          memHas, mrvHeld, mrv, mrdy, ifRr, dRr;
   logic [31:0] mrd;

   string       dutGrants;
   int          obsBase, firstIfRdy, firstMemVld, firstIfRsp, dRspCount, ifRspCount;
   logic [31:0] lastIfRspData;
   logic [68:0] lastMemReq;

   task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", name, cycle, act, exp);
      end
   endtask

   task automatic clearObs();
      dutGrants     = "";
      obsBase       = cycle;
      firstIfRdy    = -1;
      firstMemVld   = -1;
      firstIfRsp    = -1;
      dRspCount     = 0;
      ifRspCount    = 0;
      lastIfRspData = '0;
      lastMemReq    = '0;
   endtask

   task automatic driveBus();
      bus.if_req_valid  = fv;
      bus.if_req_addr   = fAddr;
      bus.d_req_valid   = dv;
      bus.d_req_we      = dWe;
      bus.d_req_addr    = dAddr;
      bus.d_req_wdata   = dWdata;
      bus.d_req_be      = dBe;
      bus.mem_req_ready = mrdy;
      bus.mem_rsp_valid = mrv;
      bus.mem_rsp_data  = mrd;
      bus.if_rsp_ready  = ifRr;
      bus.d_rsp_ready   = dRr;
   endtask

   // Pick this cycle's inputs: new requests appear only when the port is
   // idle and are held until granted; memory holds a response until taken.
   task automatic applyStimulus();
      if (!fv && ($urandom % 100) < fProb) begin
         fv    = 1'b1;
         fAddr = {22'd0, 8'($urandom), 2'b00};
      end
      if (!dv && ($urandom % 100) < dProb) begin
         dv     = 1'b1;
         dWe    = 1'($urandom);
         dAddr  = {22'd0, 8'($urandom), 2'b00};
         dWdata = $urandom;
         dBe    = 4'($urandom);
      end
      mrdy = ($urandom % 100) < mrdyProb;
      if (memHas) begin
         if (!mrvHeld && ($urandom % 100) < rspProb) begin
            mrvHeld = 1'b1;
            mrd     = memArr[tAddr[9:2]];
         end
         mrv = mrvHeld;
      end else begin
         mrvHeld = 1'b0;
         mrv     = ($urandom % 100) < strayProb;
         mrd     = $urandom;
      end
      ifRr = ($urandom % 100) < rrProb;
      dRr  = ($urandom % 100) < rrProb;
      driveBus();
   endtask

   task automatic writeMem(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] be);
      logic [31:0] w;
      w = memArr[addr[9:2]];
      for (int b = 0; b < 4; b++) begin
         if (be[b]) w[b*8 +: 8] = wd[b*8 +: 8];
      end
      memArr[addr[9:2]] = w;
   endtask

   // Compare every output against the model, log what the DUT did for the
   // directed checks, then advance the model by the handshakes of this cycle.
   task automatic checkOutput();
      bit idle, eGd, eGf, eMv, waitOwn, ownRr, eMrr, eIfRv, eDRv;
      idle    = !busy;
      eGd     = idle && dv && !(fv && streak == LIMIT);
      eGf     = idle && fv && !eGd;
      eMv     = busy && !accepted;
      waitOwn = busy && accepted;
      ownRr   = ownerData ? dRr : ifRr;
      eMrr    = waitOwn && ownRr;
      eIfRv   = waitOwn && !ownerData && mrv;
      eDRv    = waitOwn && ownerData && mrv;

      chk("if_req_ready", 80'(bus.if_req_ready), 80'(eGf));
      chk("d_req_ready", 80'(bus.d_req_ready), 80'(eGd));
      chk("mem_req_valid", 80'(bus.mem_req_valid), 80'(eMv));
      chk("mem_rsp_ready", 80'(bus.mem_rsp_ready), 80'(eMrr));
      chk("if_rsp_valid", 80'(bus.if_rsp_valid), 80'(eIfRv));
      chk("d_rsp_valid", 80'(bus.d_rsp_valid), 80'(eDRv));
      if (eMv) begin
         chk("mem_req_payload",
             80'({bus.mem_req_we, bus.mem_req_addr, bus.mem_req_wdata, bus.mem_req_be}),
             80'({tWe, tAddr, tWdata, tBe}));
      end
      if (eIfRv) chk("if_rsp_data", 80'(bus.if_rsp_data), 80'(mrd));
      if (eDRv && !tWe) chk("d_rsp_data", 80'(bus.d_rsp_data), 80'(mrd));

      if (bus.if_req_ready) begin
         dutGrants = {dutGrants, "F"};
         if (firstIfRdy < 0) firstIfRdy = cycle - obsBase;
      end
      if (bus.d_req_ready) dutGrants = {dutGrants, "D"};
      if (bus.mem_req_valid) begin
         if (firstMemVld < 0) firstMemVld = cycle - obsBase;
         lastMemReq = {bus.mem_req_we, bus.mem_req_addr, bus.mem_req_wdata, bus.mem_req_be};
      end
      if (bus.if_rsp_valid && ifRr) begin
         ifRspCount++;
         lastIfRspData = bus.if_rsp_data;
         if (firstIfRsp < 0) firstIfRsp = cycle - obsBase;
      end
      if (bus.d_rsp_valid && dRr) dRspCount++;

      if (eGd) begin
         busy = 1'b1; accepted = 1'b0; ownerData = 1'b1;
         tWe = dWe; tAddr = dAddr; tWdata = dWdata; tBe = dBe;
         dv = 1'b0;
         streak = fv ? ((streak < LIMIT) ? streak + 1 : LIMIT) : 0;
      end else if (eGf) begin
         busy = 1'b1; accepted = 1'b0; ownerData = 1'b0;
         tWe = 1'b0; tAddr = fAddr; tWdata = '0; tBe = 4'hF;
         fv = 1'b0;
         streak = 0;
      end else if (eMv && mrdy) begin
         accepted = 1'b1;
         memHas   = 1'b1;
         if (tWe) writeMem(tAddr, tWdata, tBe);
      end else if (waitOwn && mrv && ownRr) begin
         busy = 1'b0; accepted = 1'b0;
         memHas = 1'b0; mrvHeld = 1'b0; mrv = 1'b0;
      end
   endtask

   task automatic stepCycle();
      applyStimulus();
      #3;
      checkOutput();
      @(posedge clk);
      #1;
      cycle++;
   endtask

   task automatic runCycles(input int n);
      for (int i = 0; i < n; i++) stepCycle();
   endtask

   // Assert reset between edges with every input pushing to be served, check
   // that the outputs fall at once, hold reset across an edge, then release.
   task automatic doReset();
      #1;
      async_rst_n = 1'b0;
      bus.if_req_valid  = 1'b1;
      bus.d_req_valid   = 1'b1;
      bus.mem_req_ready = 1'b1;
      bus.mem_rsp_valid = 1'b1;
      bus.if_rsp_ready  = 1'b1;
      bus.d_rsp_ready   = 1'b1;
      #1;
      chk("rst_if_req_ready", 80'(bus.if_req_ready), 80'(0));
      chk("rst_d_req_ready", 80'(bus.d_req_ready), 80'(0));
      chk("rst_mem_req_valid", 80'(bus.mem_req_valid), 80'(0));
      chk("rst_mem_rsp_ready", 80'(bus.mem_rsp_ready), 80'(0));
      chk("rst_rsp_valids", 80'({bus.if_rsp_valid, bus.d_rsp_valid}), 80'(0));
      chk("rst_mem_req_payload",
          80'({bus.mem_req_we, bus.mem_req_addr, bus.mem_req_wdata, bus.mem_req_be}), 80'(0));
      busy = 1'b0; accepted = 1'b0; streak = 0;
      memHas = 1'b0; mrvHeld = 1'b0; mrv = 1'b0; mrdy = 1'b0;
      fv = 1'b0; dv = 1'b0; ifRr = 1'b0; dRr = 1'b0;
      @(posedge clk);
      #3;
      async_rst_n = 1'b1;
      driveBus();
      @(posedge clk);
      #1;
      cycle++;
   endtask

   task automatic setKnobs(input int f, input int d, input int mr, input int rs, input int rr, input int st);
      fProb = f; dProb = d; mrdyProb = mr; rspProb = rs; rrProb = rr; strayProb = st;
   endtask

   // Directed scenarios with hand-computed expectations, then a long
   // randomized run with occasional resets.
   initial begin
      for (int i = 0; i < 256; i++) memArr[i] = {8'(i), 24'hA5A5A5};
      memArr[4] = 32'h0000_0013;
      fv = 0; dv = 0; dWe = 0; fAddr = 0; dAddr = 0; dWdata = 0; dBe = 0;
      mrv = 0; mrd = 0; mrdy = 0; ifRr = 0; dRr = 0; memHas = 0; mrvHeld = 0;
      busy = 0; accepted = 0; ownerData = 1; tWe = 0; tAddr = 0; tWdata = 0; tBe = 0; streak = 0;
      async_rst_n = 1'b1;
      driveBus();
      setKnobs(0, 0, 100, 100, 100, 0);
      @(posedge clk);
      doReset();

      $display("[TB] single fetch");
      clearObs();
      fv = 1'b1; fAddr = 32'h0000_0010;
      runCycles(5);
      chk("fetch_grant_cycle", 80'(firstIfRdy), 80'(0));
      chk("fetch_memvalid_cycle", 80'(firstMemVld), 80'(1));
      chk("fetch_memreq", 80'(lastMemReq), 80'({1'b0, 32'h10, 32'h0, 4'hF}));
      chk("fetch_rsp_cycle", 80'(firstIfRsp), 80'(2));
      chk("fetch_rsp_data", 80'(lastIfRspData), 80'(32'h13));
      chk("fetch_no_drsp", 80'(dRspCount), 80'(0));

      $display("[TB] single store");
      clearObs();
      dv = 1'b1; dWe = 1'b1; dAddr = 32'h100; dWdata = 32'hDEADBEEF; dBe = 4'b0011;
      runCycles(5);
      chk("store_memreq", 80'(lastMemReq), 80'({1'b1, 32'h100, 32'hDEADBEEF, 4'b0011}));
      chk("store_drsp_count", 80'(dRspCount), 80'(1));
      chk("store_no_ifrsp", 80'(ifRspCount), 80'(0));
      total++;
      if (dutGrants != "D") begin
         bad++;
         $display("[TB] FAIL store_grants: got '%s' expected 'D'", dutGrants);
      end

      $display("[TB] reset during WAIT and stray response");
      setKnobs(0, 0, 100, 0, 100, 0);
      fv = 1'b1; fAddr = 32'h10;
      runCycles(3);
      doReset();
      setKnobs(0, 0, 100, 100, 100, 100);
      runCycles(3);
      setKnobs(0, 0, 100, 100, 100, 0);
      clearObs();
      fv = 1'b1; fAddr = 32'h10;
      runCycles(5);
      chk("postrst_fetch_count", 80'(ifRspCount), 80'(1));
      chk("postrst_fetch_data", 80'(lastIfRspData), 80'(32'h13));

      $display("[TB] memory stalls in ISSUE");
      setKnobs(100, 0, 0, 100, 100, 0);
      clearObs();
      dv = 1'b1; dWe = 1'b1; dAddr = 32'h200; dWdata = 32'h1234_5678; dBe = 4'hF;
      runCycles(6);
      total++;
      if (dutGrants != "D") begin
         bad++;
         $display("[TB] FAIL issue_stall_grants: got '%s' expected 'D'", dutGrants);
      end
      setKnobs(0, 0, 100, 100, 100, 0);
      runCycles(10);

      $display("[TB] owner back-pressure in WAIT");
      setKnobs(0, 0, 100, 100, 0, 0);
      clearObs();
      dv = 1'b1; dWe = 1'b0; dAddr = 32'h200; dBe = 4'hF;
      runCycles(6);
      chk("bp_no_drsp", 80'(dRspCount), 80'(0));
      setKnobs(0, 0, 100, 100, 100, 0);
      runCycles(3);
      chk("bp_drsp_done", 80'(dRspCount), 80'(1));

      $display("[TB] starvation sequence");
      setKnobs(100, 100, 100, 100, 100, 0);
      clearObs();
      for (int i = 0; i < 80 && dutGrants.len() < 10; i++) stepCycle();
      total++;
      if (dutGrants.len() < 10 || dutGrants.substr(0, 9) != "DDDDFDDDDF") begin
         bad++;
         $display("[TB] FAIL grant_sequence: got '%s' expected 'DDDDFDDDDF'", dutGrants);
      end
      setKnobs(0, 0, 100, 100, 100, 0);
      runCycles(20);

      $display("[TB] randomized traffic");
      for (int blk = 0; blk < 40; blk++) begin
         setKnobs($urandom_range(10, 100), $urandom_range(10, 100), $urandom_range(20, 100),
                  $urandom_range(20, 100), $urandom_range(20, 100), $urandom_range(0, 50));
         for (int i = 0; i < 100; i++) begin
            if ($urandom % 700 == 0) doReset();
            else stepCycle();
         end
      end

      $display("[TB] test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
